// File: rtl/char_buffer_writer.sv
// rtl/char_buffer_writer.sv - write-side sequencer for the character buffer (cursor, scroll, clears)
// Optional feature: define AUTOWRAP_EN to wrap printable chars past the last column into LF semantics.
module char_buffer_writer #(
  parameter int         COLS       = 64,
  parameter int         ROWS       = 16,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                                  clk,
  input  logic                                  clr_n,
  input  logic [7:0]                            din,
  input  logic                                  din_valid,
  output logic                                  din_ready,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  buffer_waddr,
  output logic [7:0]                            buffer_din,
  output logic                                  buffer_wen,
  output logic [$clog2(ROWS)-1:0]               cursor_row,
  output logic [$clog2(COLS)-1:0]               cursor_col,
  output logic [$clog2(ROWS)-1:0]               scroll_row,
  output logic                                  busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = RW + CW;
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] scroll_q, scroll_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic [RW-1:0] phys_row;
  logic          lf;

  assign phys_row = row_q + scroll_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    scroll_d = scroll_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    lf       = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid && ready_q) begin
          if (din >= 8'h20 && din <= 8'h7E) begin
            wen_d   = 1'b1;
            waddr_d = {phys_row, col_q};
            wdata_d = din;
            if (col_q != COL_MAX) begin
              col_d = col_q + 1'b1;
            end else begin
`ifdef AUTOWRAP_EN
              col_d = '0;
              lf    = 1'b1;
`endif
            end
          end else begin
            case (din)
              8'h0D: col_d = '0;
              8'h0A: lf = 1'b1;
              8'h08: if (col_q != '0) col_d = col_q - 1'b1;
              8'h0C: begin
                row_d    = '0;
                col_d    = '0;
                scroll_d = '0;
                cnt_d    = '0;
                state_d  = CLR_SCREEN;
              end
              default: ;
            endcase
          end
          if (lf) begin
            if (row_q != ROW_MAX) begin
              row_d = row_q + 1'b1;
            end else begin
              scroll_d = scroll_q + 1'b1;
              cnt_d    = '0;
              state_d  = CLR_LINE;
            end
          end
        end
      end
      CLR_LINE: begin
        // row_q is the bottom row here, so phys_row is the row just scrolled off the top
        wen_d   = 1'b1;
        wdata_d = CLEAR_CHAR;
        waddr_d = {phys_row, cnt_q[CW-1:0]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q[CW-1:0] == COL_MAX) state_d = IDLE;
      end
      CLR_SCREEN: begin
        wen_d   = 1'b1;
        wdata_d = CLEAR_CHAR;
        waddr_d = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = CLR_SCREEN;
    endcase
    // Ready only after a full idle cycle, so it rises one cycle past the last clear write
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= CLR_SCREEN;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      scroll_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      scroll_q <= scroll_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
    end
  end

  assign din_ready    = ready_q;
  assign busy         = !ready_q && clr_n;
  assign buffer_waddr = waddr_q;
  assign buffer_din   = wdata_q;
  assign buffer_wen   = wen_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;
  assign scroll_row   = scroll_q;

endmodule
